uart_rx_ovs: RTL and testbench
==============================

// Module: uart_rx_ovs
// PURPOSE
//  Parametrised UART receiver for the UART datapath. Consumes the oversample tick from the baud generator and the raw rx pin.
//  Deserialises 5-8 bit frames with optional parity (odd/even/stick) and 1 or 2 stop bits.
//  Reports parity, framing and break errors, and hands each frame to the RX FIFO over a valid/ready interface.
//  Adds input synchronisation, 3-sample majority voting, false-start rejection, LCR snapshotting, break hold-off and overrun detection.
// PARAMETERS
//  OVERSAMPLE   16  baud_pulse ticks per bit; even, >= 8
//  SYNC_STAGES  2   synchroniser flops on rx; >= 2
// PORTS
//  clk            in   1  clock
//  rst            in   1  reset, asynchronous, active-high
//  baud_pulse     in   1  oversample tick, 1-cycle strobe
//  wls            in   2  word length select: 00=5 .. 11=8 bits
//  stb            in   1  stop bits: 0=1, 1=2
//  pen            in   1  parity enable
//  eps            in   1  even parity select
//  sticky_parity  in   1  stick parity: expected bit = ~eps
//  rx             in   1  serial input, asynchronous, idle high
//  rx_data        out  8  received word, LSB-aligned, upper bits zero
//  rx_pe          out  1  parity error, qualified by rx_valid
//  rx_fe          out  1  framing error, qualified by rx_valid
//  rx_bi          out  1  break indication, qualified by rx_valid
//  rx_valid       out  1  frame available
//  rx_ready       in   1  consumer accepts frame when rx_valid & rx_ready
//  overrun        out  1  1-cycle pulse: completed frame dropped
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. Counters 0. Sync flops 1. Reset mid-frame abandons the frame; no partial output.
//  All state/counter updates happen only on baud_pulse cycles. tick counts 0..OVERSAMPLE-1 within each bit; MID=OVERSAMPLE/2.
//  Bit value = majority of synchronised rx at ticks MID-1, MID, MID+1. Decision is taken at tick MID+1.
//  States:
//   IDLE: rx_s==0 -> START, tick=0.
//   START: at MID+1, vote==1 -> IDLE (false start). At tick OVERSAMPLE-1 -> DATA.
//     On this transition: snapshot wls/stb/pen/eps/sticky_parity into frame copy; later LCR changes ignored.
//   DATA: 5+wls bits, LSB first, shifted at MID+1. After final bit period -> PARITY if pen, else STOP.
//   PARITY: at MID+1 compute pe from the vote:
//     sticky=0: pe = ^{bit,data} != ~eps (odd parity when eps=0, even when eps=1).
//     sticky=1: pe = (bit != ~eps).
//   STOP: first stop bit checked: fe = ~vote. With stb=1, the second stop bit is timed but not checked.
//     Frame completes at MID+1 of the last stop bit (half-bit early, for resync).
//   Break: data==0, parity vote==0 (if pen) and first stop vote==0 -> bi=1.
//     The frame completes normally, then state -> BRK_WAIT.
//   BRK_WAIT: stay until rx_s==1 on a baud_pulse -> IDLE. No new frame is started during the break.
//  Completion: rx_valid/rx_data/rx_pe/rx_fe/rx_bi are registered 1 clk after the completing baud_pulse.
//  Handshake: rx_valid holds, with payload stable, until rx_valid & rx_ready. Then it clears the next cycle unless a new frame loads.
//  Simultaneous completion and rx_valid & rx_ready: new frame loads, rx_valid stays 1, no overrun.
//  Completion with rx_valid & ~rx_ready: new frame dropped, old payload kept, overrun=1 for one cycle.
//  No baud_pulse -> receiver frozen; the handshake still operates.
// STRUCTURE
//  uart_pkg: lcr_t struct {wls, stb, pen, eps, sticky_parity}; rx_state_e {IDLE,START,DATA,PARITY,STOP,BRK_WAIT}; WLS_BITS function (5+wls).
//  Sub-module uart_rx_sampler: SYNC_STAGES synchroniser (reset 1) + 3-sample majority register.
//    Outputs rx_s and vote, taking tick and baud_pulse.
//  Top: FSM, tick/bit counters, shift register, parity/error logic, output register + handshake.
// TESTING (OVERSAMPLE=16, baud_pulse every 4 clk)
//  8N1, send 0xA5, rx_ready=1 -> one rx_valid, rx_data=0xA5, pe=fe=bi=0.
//  7E1, send 0x41 with parity bit 1 -> rx_data=0x41, rx_pe=1. Repeat with stick (sticky=1, eps=0) and parity 0 -> rx_pe=1.
//  rx low for 4 ticks then high -> no rx_valid, FSM back in IDLE. 8N1 0x00 with 1-tick high glitch at MID of bit 3 -> rx_data=0x00.
//  8N1, rx held low 30 bit times -> exactly one frame, rx_data=0, fe=1, bi=1. Next 0x3C after rx high -> received correctly.
//  Two frames 0x11, 0x22, rx_ready=0 -> rx_data stays 0x11, overrun pulses once. Completion on the accept cycle -> 0x22 loads, no overrun.
//  Assert rst mid-DATA, release, send 0x5A -> no stale frame; rx_data=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   lcr_t      : line-control snapshot {wls, stb, pen, eps, sticky_parity}
//   rx_state_e : receiver frame state
//   wls_bits   : data bits per frame for a word-length select code (5..8)
//   parity8    : XOR reduction of a data byte
package uart_pkg;

  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sticky_parity;
  } lcr_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_e;

  function automatic logic [3:0] wls_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver.
// Synchronises the asynchronous rx pin and forms a 3-sample majority vote
// around the bit centre.
//   clk, rst    : clock, asynchronous active-high reset
//   baud_pulse  : oversample tick strobe
//   tick        : current oversample index within the bit
//   rx          : raw serial input (idle high)
//   rx_s        : synchronised rx
//   vote        : majority of rx_s at ticks MID-1, MID and the current (MID+1) sample
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TW          = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_pulse,
  input  logic [TW-1:0] tick,
  input  logic          rx,
  output logic          rx_s,
  output logic          vote
);

  localparam logic [TW-1:0] T_MID_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2);

  logic [SYNC_STAGES-1:0] sync;
  logic [1:0]             samples;

  // Synchroniser chain; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{1'b1}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];

  // Capture the two early samples; the third is the live rx_s at MID+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples <= 2'b11;
    end else if (baud_pulse && (tick == T_MID_M1)) begin
      samples[0] <= rx_s;
    end else if (baud_pulse && (tick == T_MID)) begin
      samples[1] <= rx_s;
    end else begin
      samples <= samples;
    end
  end

  assign vote = (samples[0] & samples[1]) | (samples[0] & rx_s) | (samples[1] & rx_s);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 5-8 data bits, optional odd/even/stick parity,
// 1 or 2 stop bits, parity/framing/break reporting, valid/ready output with
// overrun detection.
//   clk, rst        : clock, asynchronous active-high reset
//   baud_pulse      : oversample tick strobe (OVERSAMPLE per bit)
//   wls/stb/pen/eps/sticky_parity : line control, sampled at end of start bit
//   rx              : serial input, idle high
//   rx_data/rx_pe/rx_fe/rx_bi : frame payload, qualified by rx_valid
//   rx_valid/rx_ready : output handshake
//   overrun         : 1-cycle pulse when a completed frame is dropped
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun
);

  localparam int            TW     = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_ZERO = TW'(0);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_MID1 = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  rx_state_e     state, state_n;
  logic [TW-1:0] tick, tick_n, tick_inc;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    data, data_n;
  lcr_t          lcr, lcr_n, lcr_in;
  logic          pe_r, pe_n, fe_r, fe_n, par_bit, par_n;
  logic          complete, fe_fin, bi_fin;
  logic          rx_s, vote;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES),
    .TW         (TW)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .baud_pulse(baud_pulse),
    .tick      (tick),
    .rx        (rx),
    .rx_s      (rx_s),
    .vote      (vote)
  );

  assign lcr_in   = {wls, stb, pen, eps, sticky_parity};
  assign tick_inc = tick + T_ONE;

  // Frame state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= T_ZERO;
      bit_cnt <= 3'd0;
      data    <= 8'd0;
      lcr     <= '0;
      pe_r    <= 1'b0;
      fe_r    <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_n;
      data    <= data_n;
      lcr     <= lcr_n;
      pe_r    <= pe_n;
      fe_r    <= fe_n;
      par_bit <= par_n;
    end
  end

  // Next-state logic; everything advances only on baud_pulse.
  always_comb begin
    state_n  = state;
    tick_n   = tick;
    bit_n    = bit_cnt;
    data_n   = data;
    lcr_n    = lcr;
    pe_n     = pe_r;
    fe_n     = fe_r;
    par_n    = par_bit;
    complete = 1'b0;
    fe_fin   = fe_r;
    bi_fin   = 1'b0;
    if (baud_pulse) begin
      case (state)
        IDLE: begin
          tick_n = T_ZERO;
          if (!rx_s) state_n = START;
          else       state_n = IDLE;
        end
        START: begin
          if ((tick == T_MID1) && vote) begin
            // Line back high at mid start bit: glitch, not a frame.
            state_n = IDLE;
            tick_n  = T_ZERO;
          end else if (tick == T_LAST) begin
            state_n = DATA;
            tick_n  = T_ZERO;
            bit_n   = 3'd0;
            data_n  = 8'd0;
            lcr_n   = lcr_in;
            pe_n    = 1'b0;
            fe_n    = 1'b0;
            par_n   = 1'b0;
          end else begin
            tick_n = tick_inc;
          end
        end
        DATA: begin
          if (tick == T_MID1) data_n[bit_cnt] = vote;
          else                data_n = data;
          if (tick == T_LAST) begin
            tick_n = T_ZERO;
            if ({1'b0, bit_cnt} == (wls_bits(lcr.wls) - 4'd1)) begin
              bit_n   = 3'd0;
              state_n = lcr.pen ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick_inc;
          end
        end
        PARITY: begin
          if (tick == T_MID1) begin
            par_n = vote;
            if (lcr.sticky_parity) pe_n = (vote != ~lcr.eps);
            else                   pe_n = ((parity8(data) ^ vote) != ~lcr.eps);
          end else begin
            par_n = par_bit;
          end
          if (tick == T_LAST) begin
            state_n = STOP;
            tick_n  = T_ZERO;
            bit_n   = 3'd0;
          end else begin
            tick_n = tick_inc;
          end
        end
        STOP: begin
          if (tick == T_MID1) begin
            // Only the first stop bit is checked; a second one is just timed.
            if (bit_cnt == 3'd0) fe_fin = ~vote;
            else                 fe_fin = fe_r;
            fe_n = fe_fin;
            if (bit_cnt == {2'b00, lcr.stb}) begin
              // Complete half a bit early so the next start edge is not missed.
              complete = 1'b1;
              bi_fin   = (data == 8'd0) && (!lcr.pen || !par_bit) && fe_fin;
              state_n  = bi_fin ? BRK_WAIT : IDLE;
              tick_n   = T_ZERO;
            end else begin
              tick_n = tick_inc;
            end
          end else if (tick == T_LAST) begin
            bit_n  = 3'd1;
            tick_n = T_ZERO;
          end else begin
            tick_n = tick_inc;
          end
        end
        BRK_WAIT: begin
          tick_n = T_ZERO;
          if (rx_s) state_n = IDLE;
          else      state_n = BRK_WAIT;
        end
        default: begin
          state_n = IDLE;
          tick_n  = T_ZERO;
        end
      endcase
    end else begin
      state_n = state;
    end
  end

  // Output payload register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= 8'd0;
      rx_pe    <= 1'b0;
      rx_fe    <= 1'b0;
      rx_bi    <= 1'b0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= data;
          rx_pe    <= pe_r;
          rx_fe    <= fe_fin;
          rx_bi    <= bi_fin;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs (OVERSAMPLE=16, baud_pulse every 4 clk).
// A bit-level sender drives rx; a frame-level reference model predicts the
// payload of every frame, and a monitor compares each accepted frame.
module tb_uart_rx_ovs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_pulse = 1'b0;
  logic [1:0] wls = 2'd3;
  logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sticky_parity = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_pe, rx_fe, rx_bi, rx_valid, overrun;

  uart_rx_ovs #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse),
    .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sticky_parity(sticky_parity),
    .rx(rx), .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    baud_pulse = (cyc % 4 == 0);
  end

  int n_cmp = 0, n_mis = 0;
  logic [10:0] exp_q[$];
  int got_frames = 0, exp_frames = 0, ovr_cnt = 0, exp_ovr = 0;
  int unsigned rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: payload {data, pe, fe, bi} of one frame from its bit values.
  function automatic logic [10:0] model(input logic [7:0] d, input int nb, input bit pen_i,
                                        input bit eps_i, input bit stk_i, input bit par_bit,
                                        input bit stop0);
    logic [7:0] m;
    int ones;
    bit good, pe_e, fe_e, bi_e;
    m = 8'(32'(d) & ((32'd1 << nb) - 32'd1));
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(m[i]);
    if (stk_i) good = !eps_i;
    else if (eps_i) good = (ones % 2 == 1);
    else good = (ones % 2 == 0);
    pe_e = pen_i && (par_bit != good);
    fe_e = !stop0;
    bi_e = (m == 8'd0) && (!pen_i || !par_bit) && !stop0;
    return {m, pe_e, fe_e, bi_e};
  endfunction

  // Monitor: compare every accepted frame against the model queue.
  initial begin
    logic [10:0] e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready) begin
          got_frames++;
          if (exp_q.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e[10:3]));
            chk("rx_pe", 32'(rx_pe), 32'(e[2]));
            chk("rx_fe", 32'(rx_fe), 32'(e[1]));
            chk("rx_bi", 32'(rx_bi), 32'(e[0]));
          end
        end
      end
      prev_valid = rx_valid;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic ticks(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic align();
    @(negedge clk);
    while (cyc % 4 != 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen_i, input bit eps_i,
                            input bit stk_i, input bit stb_i, input bit par_bit,
                            input bit stop0, input int glitch_bit, input bit scramble);
    wls = 2'(nb - 5); stb = stb_i; pen = pen_i; eps = eps_i; sticky_parity = stk_i;
    rx = 1'b0; ticks(16);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) begin
        rx = 1'b0; ticks(8); rx = 1'b1; ticks(1); rx = 1'b0; ticks(7);
      end else begin
        rx = d[i]; ticks(16);
      end
      // Line control is frozen at the start bit; later changes must not matter.
      if (i == 0 && scramble) {wls, stb, pen, eps, sticky_parity} = 6'($urandom);
    end
    if (pen_i) begin rx = par_bit; ticks(16); end
    rx = stop0; ticks(16);
    if (stb_i) begin rx = 1'b1; ticks(16); end
    rx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input int nb, input bit pen_i, input bit eps_i,
                       input bit stk_i, input bit stb_i, input bit par_bit, input bit stop0,
                       input int glitch_bit, input bit scramble, input bit expect_it);
    if (expect_it) begin
      exp_q.push_back(model(d, nb, pen_i, eps_i, stk_i, par_bit, stop0));
      exp_frames++;
    end
    send_frame(d, nb, pen_i, eps_i, stk_i, stb_i, par_bit, stop0, glitch_bit, scramble);
    ticks(32);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned t0, lat;
    logic [7:0] d;
    int nb;
    bit p, e, s, b, pb, s0;

    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_flags", 32'({rx_pe, rx_fe, rx_bi, overrun}), 32'd0);
    rst = 1'b0;
    ticks(20);
    chk("idle_valid", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;

    frame(8'hA5, 8, 0, 0, 0, 0, 0, 1, -1, 0, 1);         // 8N1
    frame(8'h41, 7, 1, 1, 0, 0, 1, 1, -1, 0, 1);         // 7E1, bad parity
    frame(8'h41, 7, 1, 0, 1, 0, 0, 1, -1, 0, 1);         // stick parity, bad
    wait_drain();

    // False start: 4 ticks low, then idle.
    rx = 1'b0; ticks(4); rx = 1'b1; ticks(48);
    chk("false_start_frames", 32'(got_frames), 32'(exp_frames));
    frame(8'h00, 8, 0, 0, 0, 0, 0, 1, 3, 0, 1);          // glitch in bit 3
    wait_drain();

    // Break: 30 bit times low gives one frame.
    wls = 2'd3; stb = 1'b0; pen = 1'b0;
    exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
    exp_frames++;
    rx = 1'b0; ticks(30 * 16); rx = 1'b1; ticks(32);
    frame(8'h3C, 8, 0, 0, 0, 0, 0, 1, -1, 0, 1);
    wait_drain();
    chk("break_frames", 32'(got_frames), 32'(exp_frames));

    // Overrun: consumer stalled over two frames.
    rx_ready = 1'b0;
    frame(8'h11, 8, 0, 0, 0, 0, 0, 1, -1, 0, 1);
    frame(8'h22, 8, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    exp_ovr++;
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    chk("ovr_pulses", 32'(ovr_cnt), 32'(exp_ovr));
    rx_ready = 1'b1;
    wait_drain();

    // Measure completion latency, then accept exactly on a completion cycle.
    align(); t0 = cyc;
    frame(8'h55, 8, 0, 0, 0, 0, 0, 1, -1, 0, 1);
    lat = rise_cyc - t0;
    chk("latency_sane", 32'(lat > 32'd600 && lat < 32'd800), 32'd1);
    wait_drain();
    rx_ready = 1'b0;
    frame(8'h33, 8, 0, 0, 0, 0, 0, 1, -1, 0, 1);
    exp_q.push_back(model(8'h44, 8, 0, 0, 0, 0, 1));
    exp_frames++;
    align(); t0 = cyc;
    fork
      send_frame(8'h44, 8, 0, 0, 0, 0, 0, 1, -1, 0);
      begin
        repeat (lat - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    ticks(32);
    chk("accept_cycle_valid", 32'(rx_valid), 32'd1);
    chk("accept_cycle_data", 32'(rx_data), 32'h44);
    chk("accept_cycle_ovr", 32'(ovr_cnt), 32'(exp_ovr));
    rx_ready = 1'b1;
    wait_drain();

    // Reset in the middle of the data bits.
    rx = 1'b0; ticks(16); rx = 1'b1; ticks(16); rx = 1'b0; ticks(16);
    rst = 1'b1; ticks(1);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1; ticks(1);
    rst = 1'b0; ticks(32);
    chk("midrst_frames", 32'(got_frames), 32'(exp_frames));
    frame(8'h5A, 8, 0, 0, 0, 0, 0, 1, -1, 0, 1);
    wait_drain();

    // Randomised frames with random line control and injected errors.
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom);
      nb = 5 + int'($urandom_range(0, 3));
      p  = 1'($urandom); e = 1'($urandom); s = 1'($urandom); b = 1'($urandom);
      pb = 1'($urandom);
      s0 = ($urandom_range(0, 5) != 0);
      frame(d, nb, p, e, s, b, pb, s0, -1, 1, 1);
    end
    wait_drain();

    chk("total_frames", 32'(got_frames), 32'(exp_frames));
    chk("total_overruns", 32'(ovr_cnt), 32'(exp_ovr));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
